// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter
// Round-robin arbiter in front of one 32-bit execution resource. Each issue
// pushes the winner's index into a tag FIFO. In-order results pop that FIFO
// and are steered back to the issuing requester one cycle later.
module shared_resource_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*32-1:0]           req_data,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            res_in_valid,
  output logic [31:0]                     res_in_data,
  input  logic                            res_in_ready,
  input  logic                            res_out_valid,
  input  logic [31:0]                     res_out_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [31:0]                     rsp_data,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_orphan
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      tag_q [MAX_INFLIGHT];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               err_q, err_d;

  logic               eligible;
  logic               found;
  logic [IW-1:0]      win;
  logic               push;
  logic               pop;

  // Round-robin selection starting at rr_ptr; eligibility uses the registered
  // count only, so a same-cycle pop never opens a slot for a grant.
  always_comb begin
    int unsigned idx;
    logic [IW-1:0] cand;
    idx      = 0;
    cand     = '0;
    found    = 1'b0;
    win      = '0;
    eligible = res_in_ready && (count_q < CW'(MAX_INFLIGHT));
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(rr_ptr_q) + k) % 32'(NUM_REQ);
      cand = IW'(idx);
      if (eligible && !found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant = '0;
    if (found) grant[win] = 1'b1;
    res_in_valid = found;
    res_in_data  = found ? req_data[32*win +: 32] : '0;
  end

  // Next-state for pointer, FIFO bookkeeping, response registers and error flag.
  always_comb begin
    push = found;
    pop  = res_out_valid && (count_q != '0);

    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      rsp_valid_d[tag_q[rd_ptr_q]] = 1'b1;
      rsp_data_d                   = res_out_data;
    end

    err_d = err_q | (res_out_valid && (count_q == '0));
  end

  // Control and response state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Tag storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= win;
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign inflight   = count_q;
  assign err_orphan = err_q;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Testbench for shared_resource_arbiter: directed vectors, scoreboard queue
// of expected responses drained by an independent monitor.
module tb_shared_resource_arbiter;

  logic          clk;
  logic          reset;
  logic [3:0]    req;
  logic [127:0]  req_data;
  logic [3:0]    grant;
  logic          res_in_valid;
  logic [31:0]   res_in_data;
  logic          res_in_ready;
  logic          res_out_valid;
  logic [31:0]   res_out_data;
  logic [3:0]    rsp_valid;
  logic [31:0]   rsp_data;
  logic [2:0]    inflight;
  logic          err_orphan;

  shared_resource_arbiter #(.NUM_REQ(4), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .res_in_valid(res_in_valid), .res_in_data(res_in_data),
    .res_in_ready(res_in_ready), .res_out_valid(res_out_valid),
    .res_out_data(res_out_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [3:0]  oh;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc;
  int          n_pass;
  int          n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every response must match the oldest expectation and arrive
  // exactly one cycle after its result was presented.
  always @(negedge clk) begin
    if (!reset && (rsp_valid != 4'b0 || (exp_q.size() > 0 && exp_q[0].due <= cyc))) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(mon_e.oh));
        chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        chk("rsp_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    res_out_valid = 1'b0;
  endtask

  task automatic ret(input logic [31:0] d, input logic [3:0] oh);
    res_out_valid = 1'b1;
    res_out_data  = d;
    exp_q.push_back('{oh: oh, data: d, due: cyc + 1});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    req           = '0;
    res_out_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    reset = 1'b1; req = '0; req_data = '0; res_in_ready = 1'b1;
    res_out_valid = 1'b0; res_out_data = '0;

    // Reset state
    #1;
    chk("rst_inflight", 64'(inflight), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_err", 64'(err_orphan), 64'h0);
    chk("rst_grant", 64'(grant), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single request
    next_cycle();
    req = 4'b0100; req_data[2*32 +: 32] = 32'hA5A5_0001;
    #1;
    chk("single_grant", 64'(grant), 64'h4);
    chk("single_valid", 64'(res_in_valid), 64'h1);
    chk("single_data", 64'(res_in_data), 64'hA5A5_0001);
    next_cycle();
    req = 4'b1111;
    #1;
    chk("single_inflight", 64'(inflight), 64'h1);
    chk("single_rrptr3", 64'(grant), 64'h8);
    #1 req = 4'b0000;
    next_cycle();
    #1 chk("withdraw_inflight", 64'(inflight), 64'h1);
    ret(32'h0000_5555, 4'b0100);
    next_cycle();
    #1 chk("single_drained", 64'(inflight), 64'h0);

    // Round-robin rotation, result 2 cycles after each issue
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hD000_0000 | 32'(i);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      req = (k < 8) ? 4'b1111 : 4'b0000;
      if (k >= 2) ret(32'hE000_0000 | 32'(k - 2), 4'b0001 << ((k - 2) % 4));
      #1;
      if (k < 8) begin
        chk("rr_grant", 64'(grant), 64'(4'b0001 << (k % 4)));
        chk("rr_data", 64'(res_in_data), 64'(32'hD000_0000 | 32'(k % 4)));
      end
      chk("rr_inflight", 64'(inflight), (k == 0) ? 64'h0 : (k == 1) ? 64'h1 : (k <= 8) ? 64'h2 : 64'h1);
    end
    next_cycle();
    #1 chk("rr_drained", 64'(inflight), 64'h0);

    // Result routing: issue 1, 3, 0 then return in order
    do_reset();
    next_cycle(); req = 4'b0010; #1 chk("route_g1", 64'(grant), 64'h2);
    next_cycle(); req = 4'b1000; #1 chk("route_g3", 64'(grant), 64'h8);
    next_cycle(); req = 4'b0001; #1 chk("route_g0", 64'(grant), 64'h1);
    next_cycle(); req = 4'b0000; #1 chk("route_inflight", 64'(inflight), 64'h3);
    ret(32'h11, 4'b0010);
    next_cycle(); ret(32'h33, 4'b1000);
    next_cycle(); ret(32'h00, 4'b0001);
    next_cycle();
    #1 chk("route_drained", 64'(inflight), 64'h0);

    // Full and backpressure
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hC0 + 32'(i);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); req = 4'b1111;
      #1 chk("fill_grant", 64'(grant), 64'(4'b0001 << k));
    end
    next_cycle();
    #1;
    chk("full_inflight", 64'(inflight), 64'h4);
    chk("full_grant", 64'(grant), 64'h0);
    chk("full_valid", 64'(res_in_valid), 64'h0);
    next_cycle(); ret(32'hF0, 4'b0001);
    #1 chk("full_pop_nogrant", 64'(grant), 64'h0);
    next_cycle();
    #1 chk("after_pop_grant", 64'(grant), 64'h1);
    next_cycle(); ret(32'hF1, 4'b0010);
    #1;
    chk("refill_inflight", 64'(inflight), 64'h4);
    chk("refill_grant", 64'(grant), 64'h0);
    next_cycle(); res_in_ready = 1'b0;
    #1;
    chk("bp_inflight", 64'(inflight), 64'h3);
    chk("bp_grant", 64'(grant), 64'h0);
    chk("bp_valid", 64'(res_in_valid), 64'h0);
    chk("bp_data", 64'(res_in_data), 64'h0);
    #1 res_in_ready = 1'b1;
    #1;
    chk("ready_grant", 64'(grant), 64'h2);
    chk("ready_data", 64'(res_in_data), 64'hC1);
    #1 req = 4'b0000;
    next_cycle(); ret(32'hF2, 4'b0100);
    next_cycle(); ret(32'hF3, 4'b1000);
    next_cycle(); ret(32'hF4, 4'b0001);

    // Orphan result
    next_cycle();
    #1 chk("orphan_pre_inflight", 64'(inflight), 64'h0);
    ret(32'hDEAD, 4'b0000);
    void'(exp_q.pop_back());
    next_cycle();
    #1;
    chk("orphan_err", 64'(err_orphan), 64'h1);
    chk("orphan_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("orphan_rsp_hold", 64'(rsp_data), 64'hF4);
    chk("orphan_inflight", 64'(inflight), 64'h0);

    // Reset mid-operation
    next_cycle(); req = 4'b1111; #1 chk("pre_rst_g1", 64'(grant), 64'h2);
    next_cycle(); #1 chk("pre_rst_g2", 64'(grant), 64'h4);
    next_cycle(); #1 chk("pre_rst_g3", 64'(grant), 64'h8);
    next_cycle(); req = 4'b0000;
    #1;
    chk("pre_rst_inflight", 64'(inflight), 64'h3);
    chk("pre_rst_err", 64'(err_orphan), 64'h1);
    #1 reset = 1'b1;
    #1;
    chk("async_inflight", 64'(inflight), 64'h0);
    chk("async_err", 64'(err_orphan), 64'h0);
    chk("async_rsp_valid", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    next_cycle(); ret(32'h77, 4'b0000);
    void'(exp_q.pop_back());
    next_cycle();
    #1;
    chk("post_rst_orphan", 64'(err_orphan), 64'h1);
    chk("post_rst_rsp", 64'(rsp_valid), 64'h0);

    next_cycle();
    next_cycle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shared_resource_arbiter.md
# shared_resource_arbiter

Round-robin arbiter that shares one 32-bit execution resource among `NUM_REQ` pipeline instances. Each pipeline's `arbiter_req`/`resource_input` pair feeds one requester slot. Each pipeline's `arbiter_grant` comes from the matching `grant` bit. The block tracks issue order in a tag FIFO so that in-order results from the resource return to the requester that issued them.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8)
- `MAX_INFLIGHT`, 4: tag FIFO depth; maximum outstanding resource operations (power of 2, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  NUM_REQ  per-requester request; level, held until granted
- `req_data`  in  NUM_REQ*32  requester i data at bits [32i+31:32i]
- `grant`  out  NUM_REQ  one-hot or zero; combinational; data accepted in any cycle where `req[i] & grant[i]`
- `res_in_valid`  out  1  operation issued to resource this cycle (= `|grant`)
- `res_in_data`  out  32  data of the granted requester; 0 when no grant
- `res_in_ready`  in  1  resource can accept an operation this cycle
- `res_out_valid`  in  1  resource result valid; results return in issue order
- `res_out_data`  in  32  resource result
- `rsp_valid`  out  NUM_REQ  registered one-hot result strobe, one cycle wide
- `rsp_data`  out  32  registered result data, broadcast to all requesters
- `inflight`  out  $clog2(MAX_INFLIGHT)+1  current tag FIFO occupancy
- `err_orphan`  out  1  sticky; set on `res_out_valid` while FIFO empty

## Operation
- State: round-robin pointer `rr_ptr` (index width), tag FIFO (entries of index width, with read pointer, write pointer and count), response registers, sticky error flag.
- Grant eligibility: `res_in_ready && count < MAX_INFLIGHT`. If not eligible, `grant` = 0.
- Selection: scan `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ` (wrap-around). The first `req` bit set wins.
- On grant to requester w:
  - `rr_ptr` ← (w+1) mod `NUM_REQ`.
  - Tag w is pushed into the FIFO.
  - `res_in_data` = `req_data[w]`.
- No grant: `rr_ptr` holds.
- On `res_out_valid` with count>0:
  - Pop tag t.
  - Next cycle: `rsp_valid` = one-hot(t), `rsp_data` = `res_out_data`.
- On `res_out_valid` with count=0:
  - FIFO unchanged, `rsp_valid` = 0.
  - `err_orphan` ← 1 and holds until reset.
- Cycles without `res_out_valid`: `rsp_valid` = 0 and `rsp_data` holds its previous value.
- Simultaneous push and pop: count unchanged and both pointers advance.
- When full, eligibility is evaluated on the registered count. A pop in the same cycle does not enable a grant. The grant follows one cycle later.
- FIFO pointers wrap modulo `MAX_INFLIGHT`.
- `inflight` = count.

## Timing
- Reset, asynchronous and applied immediately:
  - `rr_ptr` = 0, FIFO empty, `inflight` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `err_orphan` = 0.
  - Combinational outputs are therefore `grant` = 0 unless eligible, and `res_in_valid`/`res_in_data` follow `grant`.
- Reset asserted mid-operation discards all outstanding tags. Results arriving after reset release are orphans and set `err_orphan`.
- Grant path: zero latency (combinational from `req`, `res_in_ready`, `rr_ptr`, count).
- Response path: exactly one cycle from `res_out_valid` to `rsp_valid`.
- Throughput: one issue per cycle and one response per cycle, concurrently.
- Fairness: a continuously requesting requester is granted within `NUM_REQ` eligible cycles.
- `req` deasserted before grant: no state change (no tag pushed).

## Test plan
- Single request: after reset, `req`=4'b0100, `req_data[2]`=32'hA5A5_0001, `res_in_ready`=1 → same cycle `grant`=4'b0100, `res_in_data`=32'hA5A5_0001. Next cycle `rr_ptr`=3 and `inflight`=1.
- Round-robin rotation: `req`=4'b1111 held for 8 cycles, always ready, resource returns a result 2 cycles after each issue → grants 0,1,2,3,0,1,2,3. `grant` is forced to 0 whenever `inflight` reaches `MAX_INFLIGHT`.
- Result routing: issue from requesters 1, 3, 0, then resource returns 32'h11, 32'h33, 32'h00 → `rsp_valid` = 4'b0010, 4'b1000, 4'b0001 on consecutive cycles, each one cycle after its `res_out_valid`, with matching `rsp_data`.
- Full and backpressure:
  - Fill 4 tags with no returns → `grant`=0 with `req` held.
  - Return one result → still no grant in that cycle. Grant in the next cycle, `inflight` back to 4.
  - `res_in_ready`=0 → `grant`=0 and `res_in_valid`=0 regardless of `req`.
- Orphan and reset:
  - `res_out_valid` while empty → `err_orphan`=1 and `rsp_valid`=0.
  - Assert `reset` with `inflight`=3, mid-cycle → `inflight`=0, `err_orphan`=0 and `rsp_valid`=0 immediately, without waiting for a clock edge.
